// File: rtl/vid2is_pkg.sv
// rtl/vid2is_pkg.sv - packet type codes, FSM encoding and control-packet nibble lookup
package vid2is_pkg;

  localparam logic [3:0] TYPE_CTRL        = 4'hF;
  localparam logic [3:0] TYPE_VIDEO       = 4'h0;
  localparam int         NUM_CTRL_NIBBLES = 9;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEASURE  = 3'd1,
    ST_CTRL     = 3'd2,
    ST_WAIT_SOF = 3'd3,
    ST_VIDEO    = 3'd4,
    ST_SKIP     = 3'd5
  } state_e;

  // Payload order: width MS nibble first, then height, then the interlace nibble.
  function automatic logic [3:0] ctrl_nibble(input logic [3:0]  idx,
                                             input logic [15:0] w,
                                             input logic [15:0] h,
                                             input logic [3:0]  il);
    logic [3:0] n;
    case (idx)
      4'd0:    n = w[15:12];
      4'd1:    n = w[11:8];
      4'd2:    n = w[7:4];
      4'd3:    n = w[3:0];
      4'd4:    n = h[15:12];
      4'd5:    n = h[11:8];
      4'd6:    n = h[7:4];
      4'd7:    n = h[3:0];
      4'd8:    n = il;
      default: n = 4'h0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vid2is_skid2.sv
// rtl/vid2is_skid2.sv - two-entry elastic buffer with push, pop and flush
module vid2is_skid2 #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q, wr_ptr_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);
  assign cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/vid2is_ctrl_packet_gen.sv
// rtl/vid2is_ctrl_packet_gen.sv - measures field dimensions and emits Avalon-ST Video control
// packets and video headers ahead of the Vid2IS write buffer
module vid2is_ctrl_packet_gen
  import vid2is_pkg::*;
#(
  parameter int DATA_WIDTH              = 20,
  parameter int NUMBER_OF_COLOUR_PLANES = 2,
  parameter int BPS                     = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hd_sdn,
  input  logic                  vid_locked,
  input  logic                  vid_valid,
  input  logic [DATA_WIDTH-1:0] vid_data,
  input  logic                  vid_eol,
  input  logic                  vid_eof,
  input  logic                  vid_sof,
  input  logic                  vid_f,
  input  logic                  vid_interlaced,
  output logic                  wrreq_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  packet_out,
  output logic                  early_eop,
  output logic [15:0]           width_out,
  output logic [15:0]           height_out,
  output logic                  dim_error
);

  state_e state_q, state_d;

  logic                  wr_q, wr_d, pkt_q, pkt_d, eop_q, eop_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  hdr_sent_q, hdr_sent_d, type_sent_q, type_sent_d;
  logic [3:0]            nib_q, nib_d, planes, il_q;
  logic [15:0]           sample_cnt_q, line_cnt_q, first_len_q, width_q, height_q;
  logic [15:0]           line_len, first_len_nx, line_cnt_nx;
  logic                  dim_err_q, counting, ctrl_last, ctrl_done;

  logic                  buf_push, buf_pop, buf_flush, buf_empty;
  logic [DATA_WIDTH:0]   buf_dout;

  vid2is_skid2 #(.W(DATA_WIDTH + 1)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .flush_i (buf_flush),
    .din_i   ({1'b0, vid_data}),
    .dout_o  (buf_dout),
    .empty_o (buf_empty)
  );

  assign planes    = hd_sdn ? 4'(NUMBER_OF_COLOUR_PLANES) : 4'd1;
  assign ctrl_last = ({1'b0, nib_q} + {1'b0, planes}) >= 5'(NUM_CTRL_NIBBLES);
  assign ctrl_done = (state_q == ST_CTRL) && buf_empty && type_sent_q && ctrl_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!vid_locked) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_MEASURE;
        ST_MEASURE:  if (vid_eof) state_d = ST_CTRL;
        ST_CTRL:     if (ctrl_done) state_d = ST_WAIT_SOF;
        ST_WAIT_SOF: if (vid_sof) state_d = ST_VIDEO;
        ST_VIDEO:    if (vid_eof) state_d = ST_CTRL;
                     else if (vid_sof) state_d = ST_SKIP;
        ST_SKIP:     if (vid_eof) state_d = ST_CTRL;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // The header displaces the first sample into the buffer; from then on every
  // sample goes through it one cycle late until an idle cycle drains it.
  always_comb begin
    wr_d        = 1'b0;
    data_d      = '0;
    pkt_d       = 1'b0;
    eop_d       = 1'b0;
    buf_push    = 1'b0;
    buf_pop     = 1'b0;
    buf_flush   = 1'b0;
    hdr_sent_d  = 1'b0;
    type_sent_d = 1'b0;
    nib_d       = '0;
    if (!vid_locked) begin
      buf_flush = 1'b1;
      eop_d     = (state_q == ST_VIDEO);
    end else begin
      case (state_q)
        ST_VIDEO: begin
          hdr_sent_d = hdr_sent_q;
          if (vid_sof && !vid_eof) begin
            eop_d     = 1'b1;
            buf_flush = 1'b1;
          end else if (vid_valid) begin
            wr_d = 1'b1;
            if (!hdr_sent_q) begin
              pkt_d       = 1'b1;
              data_d[3:0] = TYPE_VIDEO;
              buf_push    = 1'b1;
              hdr_sent_d  = 1'b1;
            end else if (!buf_empty) begin
              {pkt_d, data_d} = buf_dout;
              buf_pop         = 1'b1;
              buf_push        = 1'b1;
            end else begin
              data_d = vid_data;
            end
          end else if (!buf_empty) begin
            wr_d            = 1'b1;
            {pkt_d, data_d} = buf_dout;
            buf_pop         = 1'b1;
          end
        end
        ST_CTRL: begin
          type_sent_d = type_sent_q;
          nib_d       = nib_q;
          if (!buf_empty) begin
            wr_d            = 1'b1;
            {pkt_d, data_d} = buf_dout;
            buf_pop         = 1'b1;
          end else begin
            wr_d  = 1'b1;
            pkt_d = 1'b1;
            if (!type_sent_q) begin
              data_d[3:0] = TYPE_CTRL;
              type_sent_d = 1'b1;
            end else begin
              for (int p = 0; p < NUMBER_OF_COLOUR_PLANES; p++) begin
                if (p == 0 || hd_sdn)
                  data_d[p*BPS +: 4] = ctrl_nibble(nib_q + 4'(p), width_q, height_q, il_q);
              end
              nib_d = nib_q + planes;
              if (ctrl_last) begin
                type_sent_d = 1'b0;
                nib_d       = '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q        <= 1'b0;
      data_q      <= '0;
      pkt_q       <= 1'b0;
      eop_q       <= 1'b0;
      hdr_sent_q  <= 1'b0;
      type_sent_q <= 1'b0;
      nib_q       <= '0;
    end else begin
      wr_q        <= wr_d;
      data_q      <= data_d;
      pkt_q       <= pkt_d;
      eop_q       <= eop_d;
      hdr_sent_q  <= hdr_sent_d;
      type_sent_q <= type_sent_d;
      nib_q       <= nib_d;
    end
  end

  // Width is taken from the first line of the field; later lines only feed the mismatch check.
  assign counting     = vid_locked && (state_q == ST_MEASURE || state_q == ST_VIDEO || state_q == ST_SKIP);
  assign line_len     = (vid_valid && sample_cnt_q != 16'hFFFF) ? sample_cnt_q + 16'd1 : sample_cnt_q;
  assign first_len_nx = (vid_eol && line_cnt_q == 16'd0) ? line_len : first_len_q;
  assign line_cnt_nx  = (vid_eol && line_cnt_q != 16'hFFFF) ? line_cnt_q + 16'd1 : line_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_q <= '0;
      line_cnt_q   <= '0;
      first_len_q  <= '0;
      width_q      <= '0;
      height_q     <= '0;
      il_q         <= '0;
      dim_err_q    <= 1'b0;
    end else begin
      if (!counting || vid_sof || vid_eof) begin
        sample_cnt_q <= '0;
        line_cnt_q   <= '0;
        first_len_q  <= '0;
      end else begin
        if (vid_eol)        sample_cnt_q <= '0;
        else if (vid_valid) sample_cnt_q <= line_len;
        line_cnt_q  <= line_cnt_nx;
        first_len_q <= first_len_nx;
      end
      if (counting && vid_eof) begin
        width_q  <= hd_sdn ? first_len_nx : first_len_nx >> 1;
        height_q <= line_cnt_nx;
        il_q     <= vid_interlaced ? {1'b1, ~vid_f, 2'b00} : 4'b0000;
      end
      if (counting && vid_eol && line_cnt_q != 16'd0 && line_len != first_len_q)
        dim_err_q <= 1'b1;
      if (vid_locked && state_q == ST_CTRL && vid_valid)
        dim_err_q <= 1'b1;
    end
  end

  assign wrreq_out  = wr_q;
  assign data_out   = data_q;
  assign packet_out = pkt_q;
  assign early_eop  = eop_q;
  assign width_out  = width_q;
  assign height_out = height_q;
  assign dim_error  = dim_err_q;

endmodule

// File: tb/tb_vid2is_ctrl_packet_gen.sv
// tb/tb_vid2is_ctrl_packet_gen.sv - scoreboard bench for vid2is_ctrl_packet_gen
module tb_vid2is_ctrl_packet_gen;

  logic        clk = 1'b0, rst = 1'b1;
  logic        hd_sdn = 1'b1, vid_locked = 1'b0, vid_valid = 1'b0;
  logic        vid_eol = 1'b0, vid_eof = 1'b0, vid_sof = 1'b0, vid_f = 1'b0, vid_interlaced = 1'b0;
  logic [19:0] vid_data = '0;
  logic        wrreq_out, packet_out, early_eop, dim_error;
  logic [19:0] data_out;
  logic [15:0] width_out, height_out;

  int          checks = 0, errors = 0;
  logic [20:0] exp_q [$];
  logic [20:0] mon_exp;

  always #5 clk = ~clk;

  vid2is_ctrl_packet_gen dut (
    .clk(clk), .rst(rst), .hd_sdn(hd_sdn), .vid_locked(vid_locked), .vid_valid(vid_valid),
    .vid_data(vid_data), .vid_eol(vid_eol), .vid_eof(vid_eof), .vid_sof(vid_sof), .vid_f(vid_f),
    .vid_interlaced(vid_interlaced), .wrreq_out(wrreq_out), .data_out(data_out),
    .packet_out(packet_out), .early_eop(early_eop), .width_out(width_out),
    .height_out(height_out), .dim_error(dim_error)
  );

  always @(negedge clk) begin
    if (!rst && wrreq_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got pkt=%0b data=%05h, expected no write", packet_out, data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({packet_out, data_out} !== mon_exp) begin
          errors++;
          $display("FAIL beat: got pkt=%0b data=%05h, expected pkt=%0b data=%05h",
                   packet_out, data_out, mon_exp[20], mon_exp[19:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [19:0] d, input logic eol, input logic eof, input logic sof);
    vid_valid = v; vid_data = d; vid_eol = eol; vid_eof = eof; vid_sof = sof;
    @(posedge clk); #1;
    vid_valid = 1'b0; vid_data = '0; vid_eol = 1'b0; vid_eof = 1'b0; vid_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [3:0] exp_nib(input logic [35:0] v, input int k);
    if (k > 8) return 4'h0;
    return v[35-4*k -: 4];
  endfunction

  task automatic push_ctrl(input logic hd, input logic [15:0] w, input logic [15:0] h,
                           input logic [3:0] il, input int nbeats);
    logic [35:0] v;
    logic [20:0] b [$];
    v = {w, h, il};
    b.push_back({1'b1, 16'h0, 4'hF});
    if (hd) for (int i = 0; i < 5; i++) b.push_back({1'b1, 6'h0, exp_nib(v, 2*i+1), 6'h0, exp_nib(v, 2*i)});
    else    for (int i = 0; i < 9; i++) b.push_back({1'b1, 16'h0, exp_nib(v, i)});
    for (int i = 0; i < nbeats && i < b.size(); i++) exp_q.push_back(b[i]);
  endtask

  task automatic send_lines(input int nlines, input int spl, input int short_line,
                            input bit video, input logic [19:0] base);
    bit          first;
    int          n;
    logic [19:0] d;
    first = 1'b1;
    for (int l = 0; l < nlines; l++) begin
      n = (l == short_line) ? spl - 1 : spl;
      for (int s = 0; s < n; s++) begin
        d = base + 20'(l*32 + s);
        if (video) begin
          if (first) exp_q.push_back(21'h100000);
          exp_q.push_back({1'b0, d});
        end
        first = 1'b0;
        drive(1'b1, d, (s == n-1), 1'b0, 1'b0);
      end
      idle(3);
    end
  endtask

  task automatic send_sof();
    drive(1'b0, 20'h0, 1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic send_eof();
    drive(1'b0, 20'h0, 1'b0, 1'b1, 1'b0);
    idle(20);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wrreq", wrreq_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_packet", packet_out, 0);
    chk("rst_eop", early_eop, 0);
    chk("rst_width", width_out, 0);
    chk("rst_height", height_out, 0);
    chk("rst_dim_error", dim_error, 0);
    rst = 1'b0;
    vid_locked = 1'b1;
    idle(3);

    // HD progressive 8x4: measured field, then a passed-through field
    send_sof(); send_lines(4, 8, -1, 0, 20'h01000); push_ctrl(1, 16'd8, 16'd4, 4'h0, 99); send_eof();
    chk("hd_width", width_out, 8);
    chk("hd_height", height_out, 4);
    send_sof(); send_lines(4, 8, -1, 1, 20'h02000); push_ctrl(1, 16'd8, 16'd4, 4'h0, 99); send_eof();

    // SD sequential: 16 symbols per line is 8 pixels
    hd_sdn = 1'b0;
    send_sof(); send_lines(3, 16, -1, 1, 20'h03000); push_ctrl(0, 16'd8, 16'd3, 4'h0, 99); send_eof();
    chk("sd_width", width_out, 8);
    chk("sd_height", height_out, 3);

    // interlaced field ids
    hd_sdn = 1'b1; vid_interlaced = 1'b1; vid_f = 1'b0;
    send_sof(); send_lines(2, 4, -1, 1, 20'h04000); push_ctrl(1, 16'd4, 16'd2, 4'b1100, 99); send_eof();
    vid_f = 1'b1;
    send_sof(); send_lines(2, 4, -1, 1, 20'h04800); push_ctrl(1, 16'd4, 16'd2, 4'b1000, 99); send_eof();
    vid_interlaced = 1'b0; vid_f = 1'b0;

    // truncated field
    send_sof(); send_lines(2, 8, -1, 1, 20'h05000);
    drive(1'b0, 20'h0, 1'b0, 1'b0, 1'b1);
    chk("trunc_eop_high", early_eop, 1);
    chk("trunc_no_write", wrreq_out, 0);
    idle(1);
    chk("trunc_eop_low", early_eop, 0);
    send_lines(4, 8, -1, 0, 20'h06000); push_ctrl(1, 16'd8, 16'd4, 4'h0, 99); send_eof();
    chk("trunc_height", height_out, 4);

    // lock loss mid-line in VIDEO
    send_sof();
    exp_q.push_back(21'h100000); exp_q.push_back({1'b0, 20'h09000}); exp_q.push_back({1'b0, 20'h09001});
    drive(1'b1, 20'h09000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 20'h09001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 20'h09002, 1'b0, 1'b0, 1'b0);
    vid_locked = 1'b0;
    idle(1);
    chk("lock_video_eop", early_eop, 1);
    chk("lock_video_wrreq", wrreq_out, 0);
    idle(1);
    chk("lock_video_eop_low", early_eop, 0);

    // lock loss mid-CTRL: only the first three beats escape
    vid_locked = 1'b1; idle(2);
    send_sof(); send_lines(4, 8, -1, 0, 20'h0A000); push_ctrl(1, 16'd8, 16'd4, 4'h0, 3);
    drive(1'b0, 20'h0, 1'b0, 1'b1, 1'b0);
    idle(3);
    vid_locked = 1'b0;
    idle(1);
    chk("lock_ctrl_wrreq", wrreq_out, 0);
    chk("lock_ctrl_data", data_out, 0);
    chk("lock_ctrl_packet", packet_out, 0);
    chk("lock_ctrl_eop", early_eop, 0);
    idle(2);

    // asynchronous reset mid-field
    vid_locked = 1'b1; idle(2);
    send_sof(); send_lines(4, 8, -1, 0, 20'h0B000); push_ctrl(1, 16'd8, 16'd4, 4'h0, 99); send_eof();
    send_sof();
    exp_q.push_back(21'h100000); exp_q.push_back({1'b0, 20'h0C000}); exp_q.push_back({1'b0, 20'h0C001});
    drive(1'b1, 20'h0C000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 20'h0C001, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 20'h0C002, 1'b0, 1'b0, 1'b0);
    idle(1);
    #1 rst = 1'b1;
    #1;
    chk("arst_wrreq", wrreq_out, 0);
    chk("arst_data", data_out, 0);
    chk("arst_packet", packet_out, 0);
    chk("arst_width", width_out, 0);
    chk("arst_height", height_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);

    // short second line flags dim_error, which then stays set
    chk("dim_error_clear", dim_error, 0);
    send_sof(); send_lines(4, 8, 1, 0, 20'h0D000); push_ctrl(1, 16'd8, 16'd4, 4'h0, 99); send_eof();
    chk("dim_error_set", dim_error, 1);
    chk("dim_width", width_out, 8);
    send_sof(); send_lines(4, 8, -1, 1, 20'h0E000); push_ctrl(1, 16'd8, 16'd4, 4'h0, 99); send_eof();
    chk("dim_error_sticky", dim_error, 1);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
